mul_seq_ctrl: RTL and testbench

//  Sequencer for the multi-cycle multiply (ALU control code 4'd1) in EX.

---
 rtl/alu_pkg.sv | 18 +
 rtl/mul_shift_add_dp.sv | 37 +++
 rtl/mul_seq_ctrl.sv | 91 +++++++++
 tb/tb_mul_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes decoded in EX and the multiply sequencer states.
package alu_pkg;

  localparam logic [3:0] ALU_MUL  = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLLI = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_BEQ  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_BGE  = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add datapath: one multiplier bit is consumed per step.
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  // Only the low half is kept, so the add simply wraps.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle multiply sequencer for EX: accepts a multiply, stalls the pipe for
// WIDTH shift-add steps, then pulses res_valid with the low product half.
module mul_seq_ctrl
  import alu_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = ALU_MUL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_ctrl,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_t       state;
  mul_state_t       next_state;
  logic [CNT_W-1:0] cnt;
  logic             is_mul;
  logic             load;
  logic             step;
  logic             last_step;
  logic [WIDTH-1:0] acc_next;

  assign is_mul    = op_valid & (alu_ctrl == MUL_CODE) & ~flush;
  // DONE drops stall so the instruction retires once and is not re-accepted.
  assign stall     = is_mul & (state != DONE);
  assign last_step = step & (cnt == CNT_LAST);
  assign dbg_state = state;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (is_mul) begin
          load       = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        step = ~flush;
        if (cnt == CNT_LAST) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      result    <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      busy      <= (next_state != IDLE);
      res_valid <= last_step;
      if (load) cnt <= '0;
      else if (step) cnt <= cnt + CNT_W'(1);
      if (last_step) result <= acc_next;
    end
  end

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .op_a    (op_a),
    .op_b    (op_b),
    .acc_next(acc_next)
  );

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: products are queued at issue and compared at res_valid.
// Handshake: a multiply is issued by holding op_valid=1/alu_ctrl=MUL while stall=1;
// the instruction retires in the cycle stall drops with res_valid=1.
module tb_mul_seq_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   alu_ctrl;
  logic         op_valid;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         res_valid;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(W), .MUL_CODE(ALU_MUL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_ctrl (alu_ctrl),
    .op_valid (op_valid),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .res_valid(res_valid),
    .result   (result),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    op_valid = 1'b0;
    alu_ctrl = ALU_ADD;
    op_a     = '0;
    op_b     = '0;
    flush    = 1'b0;
  endtask

  // Called just after a rising edge; expectation is the truncated product.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    op_valid = 1'b1;
    alu_ctrl = ALU_MUL;
    op_a     = a;
    op_b     = b;
    p        = a * b;
    exp_q.push_back(p);
  endtask

  // Walks the stall window; returns just after the edge that leaves DONE.
  task automatic wait_result(input string tag);
    int  cyc;
    int  stall_bad;
    bit  seen;
    logic [W-1:0] exp_v;
    cyc       = 0;
    stall_bad = 0;
    seen      = 1'b0;
    for (int i = 0; i < 45 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1;
        check({tag, "_stall_done"}, W'(stall), W'(0));
        check({tag, "_latency"}, W'(cyc), W'(33));
        check({tag, "_stall_bad"}, W'(stall_bad), W'(0));
        if (exp_q.size() == 0) begin
          check({tag, "_queue_empty"}, W'(1), W'(0));
        end else begin
          exp_v = exp_q.pop_front();
          check({tag, "_result"}, result, exp_v);
        end
      end else begin
        if (stall !== 1'b1) stall_bad++;
        cyc++;
      end
    end
    if (!seen) check({tag, "_timeout"}, W'(0), W'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int bad;
    logic [3:0] codes [6];
    codes = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLLI, ALU_BEQ, ALU_BGE};

    // Reset
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_res_valid", W'(res_valid), W'(0));
    check("rst_result", result, W'(0));
    check("rst_stall", W'(stall), W'(0));
    check("rst_state", W'(dbg_state), W'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 3*5
    issue(32'd3, 32'd5);
    wait_result("basic");
    drive_idle();
    @(negedge clk);
    check("basic_idle_busy", W'(busy), W'(0));
    check("basic_hold", result, W'(15));
    @(posedge clk);
    #1;

    // Flush 7*9 ten cycles after accept: result must keep 15
    op_valid = 1'b1; alu_ctrl = ALU_MUL; op_a = 32'd7; op_b = 32'd9;
    @(negedge clk);
    check("flush_accept_stall", W'(stall), W'(1));
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_stall", W'(stall), W'(0));
    check("flush_busy_state", W'(dbg_state), W'(BUSY));
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    check("flush_idle", W'(dbg_state), W'(IDLE));
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) pulses++;
      @(negedge clk);
    end
    check("flush_no_pulse", W'(pulses), W'(0));
    check("flush_result_kept", result, W'(15));
    @(posedge clk);
    #1;

    // Wrap cases
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("wrap_ff");
    issue(32'h8000_0000, 32'd2);
    wait_result("wrap_msb");
    drive_idle();

    // Non-multiply codes, then a bubble carrying the multiply code
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      op_valid = 1'b1; alu_ctrl = codes[c];
      op_a = $urandom; op_b = $urandom;
      repeat (3) begin
        @(negedge clk);
        if (stall !== 1'b0 || busy !== 1'b0) bad++;
        @(posedge clk);
        #1;
      end
    end
    check("nonmul_quiet", W'(bad), W'(0));
    op_valid = 1'b0; alu_ctrl = ALU_MUL;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (stall !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    check("bubble_quiet", W'(bad), W'(0));

    // Back-to-back: second issue lands in the IDLE cycle right after DONE
    issue(32'd6, 32'd7);
    wait_result("b2b_first");
    issue(32'h0001_0000, 32'h0001_0000);
    wait_result("b2b_second");
    for (int k = 0; k < 3; k++) begin
      issue(W'($urandom_range(1, 32'hFFFF)), $urandom);
      wait_result("rand");
    end
    drive_idle();

    // Reset in the middle of BUSY
    issue(32'd11, 32'd13);
    void'(exp_q.pop_back());
    repeat (6) @(posedge clk);
    #1 begin rst_n = 1'b0; op_valid = 1'b0; end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_state", W'(dbg_state), W'(IDLE));
    check("midrst_result", result, W'(0));
    check("midrst_res_valid", W'(res_valid), W'(0));
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
